vfpu_add_pipe: RTL and testbench
================================

Name: vfpu_add_pipe

Overview:
Parametrised, pipelined floating-point add/subtract core for the VFPU datapath.
- Accepts unpacked operands (sign, biased exponent, mantissa with implied bit) and an add/sub opcode.
- Produces a pre-normalisation result (sign, signed exponent, mantissa with carry/guard/round/sticky) for the downstream normaliser/rounder.
- Three register stages with valid/ready flow control and a sideband tag, so back-to-back vector lanes stream at one result per cycle.

Parameters:
EXP_W, 8, exponent field width
MANT_W, 23, stored mantissa width (implied bit excluded)
TAG_W, 4, width of opaque tag carried alongside each operation

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
in_valid_i  in  1  operand set valid
in_ready_o  out  1  core can accept operands this cycle
op_sub_i  in  1  0: A+B, 1: A-B
tag_i  in  TAG_W  sideband tag
signA_i, signB_i  in  1  operand signs
expA_i, expB_i  in  EXP_W  biased exponents
mantA_i, mantB_i  in  MANT_W+1  mantissas incl. implied bit
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
tag_o  out  TAG_W  tag of the result
sign_o  out  1  result sign
exp_o  out  EXP_W+2  signed pre-norm exponent: zero-extended larger exponent
mant_o  out  MANT_W+5  {carry, MANT_W+1 magnitude bits, G, R, S}

Behaviour:
- Reset:
  - All stage valid bits 0, so out_valid_o=0 and in_ready_o=1.
  - All data registers 0, so sign_o, exp_o, mant_o and tag_o read 0.
  - Reset asserted mid-operation discards every in-flight operation; no result is emitted for it.
- Handshake:
  - Transfer occurs on valid&ready.
  - Each stage loads when it is empty or when its downstream stage advances (standard elastic pipeline).
  - in_ready_o = ~v1 | advance1. It is combinational from out_ready_i through the stage enables; no skid buffer.
  - Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- Latency and throughput: 3 cycles from accepted input to out_valid_o when unstalled; one operation per cycle sustained.
- Stage 1 (compare/swap):
  - Effective sign of B: signB_i ^ op_sub_i.
  - Larger operand: exponent compare first; on equal exponents, mantissa compare; on full equality, A is larger.
  - Register: larger exponent, d = |expA-expB|, big mantissa, small mantissa, effective-subtract flag eff_sub = signA ^ effective signB, sign of the larger operand, tag.
- Stage 2 (align):
  - Small mantissa is extended by 3 zero bits (G, R, S) and shifted right by d.
  - S is the OR of all bits shifted out at or beyond the S position.
  - If d >= MANT_W+4, the shifted value is 0 and S = OR of the small mantissa.
  - Big mantissa is extended with 3 zero bits.
- Stage 3 (add/sub):
  - If eff_sub: result = big - shifted, computed as inverted shifted plus carry-in 1, with the carry bit forced to 0. Otherwise result = big + shifted, keeping the carry.
  - Because the larger operand is always the minuend, the result is never negative.
  - sign_o = sign of larger operand.
  - Exact zero result under eff_sub: sign_o = 0 (round-to-nearest convention).
  - exp_o = signed zero extension of the larger exponent.
- Special encodings (zero/denormal/Inf/NaN) are not interpreted unless the optional feature is enabled. Exponent fields are treated arithmetically.

Optional Feature:
Macro VFPU_ADD_SPECIAL_EN.
- Defined:
  - Adds output port special_o (3 bits: {nan, inf, zero_exact}), pipelined with the data.
  - An operand with exponent all-ones and nonzero stored mantissa gives nan=1.
  - Inf + (-Inf) under eff_sub gives nan=1.
  - Any other Inf operand gives inf=1, with sign_o = sign of that Inf.
  - When nan=1 or inf=1, mant_o is forced to 0.
- Undefined: port absent; no special detection logic.

Decomposition:
- Package hwpe_ctrl_vfpu_package holds:
  - Derived width constants: MANT_ALIGN_W = MANT_W+4 and EXP_PRENORM_W = EXP_W+2.
  - Typedef vfpu_add_s1_t for the stage-1 register bundle.
  - Typedef vfpu_add_s2_t for the stage-2 register bundle.
- One natural sub-module: vfpu_align_shift. It is purely combinational and implements the right shift plus sticky generation, with width as a parameter.

Test Plan:
- 1.0+1.0: exp 127/127, mant 0x800000/0x800000, op_sub=0 → after 3 cycles exp_o=127, mant_o=0x8000000 (carry=1), sign_o=0.
- 1.5-1.5: mant 0xC00000 both, op_sub=1 → mant_o=0, sign_o=0. Repeat with both signs negative → sign_o=0.
- Far alignment: A exp 127 mant 0x800000, B exp 97 mant 0x800000 (d=30) → mant_o=0x4000001 (S=1), exp_o=127.
- Smaller-minus-larger: A=1.0 (exp 127), B=2.0 (exp 128), op_sub=1 → sign_o=1, exp_o=128, mant_o=0x2000000.
- Backpressure: stream 5 operations with out_ready_i=0 → in_ready_o falls after 3 are accepted; outputs stay stable. Releasing out_ready_i drains all 5 in order with tags intact, one per cycle.
- Reset: assert rst_i with 2 operations in flight → out_valid_o=0 immediately and in_ready_o=1; no stale result appears after deassertion.

Source files
------------

// File: rtl/vfpu_add_pipe_pkg.sv
// Shared widths and stage-register bundles for the VFPU add/sub pipeline.
// Optional macro VFPU_ADD_SPECIAL_EN adds NaN/Inf tracking fields to the bundles.
// The bundles are sized from the package widths, so a build that overrides
// EXP_W/MANT_W/TAG_W on vfpu_add_pipe must change the VFPU_* values here too.
package hwpe_ctrl_vfpu_package;

    localparam int VFPU_EXP_W  = 8;
    localparam int VFPU_MANT_W = 23;
    localparam int VFPU_TAG_W  = 4;

    // Implied bit + stored mantissa + guard/round/sticky
    localparam int MANT_ALIGN_W  = VFPU_MANT_W + 4;
    // Pre-normalisation exponent leaves headroom for the normaliser
    localparam int EXP_PRENORM_W = VFPU_EXP_W + 2;

    // Compare/swap results
    typedef struct packed {
        logic [VFPU_TAG_W-1:0]  tag;
        logic                   bigSign;
        logic                   effSub;
        logic [VFPU_EXP_W-1:0]  bigExp;
        logic [VFPU_EXP_W-1:0]  expDiff;
        logic [VFPU_MANT_W:0]   bigMant;
        logic [VFPU_MANT_W:0]   smallMant;
`ifdef VFPU_ADD_SPECIAL_EN
        logic                   isNan;
        logic                   isInf;
        logic                   infSign;
`endif
    } vfpu_add_s1_t;

    // Aligned operands ready for the adder
    typedef struct packed {
        logic [VFPU_TAG_W-1:0]   tag;
        logic                    bigSign;
        logic                    effSub;
        logic [VFPU_EXP_W-1:0]   bigExp;
        logic [MANT_ALIGN_W-1:0] bigAligned;
        logic [MANT_ALIGN_W-1:0] smallAligned;
`ifdef VFPU_ADD_SPECIAL_EN
        logic                    isNan;
        logic                    isInf;
        logic                    infSign;
`endif
    } vfpu_add_s2_t;

endpackage

// File: rtl/vfpu_align_shift.sv
// Combinational right shifter with sticky collection for mantissa alignment.
// Bit 0 of the result is the sticky position: it absorbs every bit shifted
// past it. Shift amounts of WIDTH or more collapse to a lone sticky bit.
module vfpu_align_shift
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int WIDTH   = MANT_ALIGN_W,
    parameter int SHIFT_W = VFPU_EXP_W
) (
    input  logic [WIDTH-1:0]   dataIn,
    input  logic [SHIFT_W-1:0] shAmt,
    output logic [WIDTH-1:0]   dataOut
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] lostMask;

    // Shift right and fold the discarded bits into the sticky position
    always_comb begin
        shifted  = '0;
        lostMask = '0;
        dataOut  = '0;
        if (32'(shAmt) >= WIDTH) begin
            dataOut = {{(WIDTH-1){1'b0}}, |dataIn};
        end else begin
            shifted  = dataIn >> shAmt;
            lostMask = ~({WIDTH{1'b1}} << shAmt);
            dataOut  = {shifted[WIDTH-1:1], shifted[0] | (|(dataIn & lostMask))};
        end
    end

endmodule

// File: rtl/vfpu_add_pipe.sv
// Three-stage floating-point add/subtract core producing a pre-normalised
// result: compare/swap, align, add/sub. Elastic valid/ready pipeline with a
// sideband tag. Optional macro VFPU_ADD_SPECIAL_EN adds special_o
// ({nan, inf, zero_exact}) and NaN/Inf handling.
module vfpu_add_pipe
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int EXP_W  = VFPU_EXP_W,
    parameter int MANT_W = VFPU_MANT_W,
    parameter int TAG_W  = VFPU_TAG_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              op_sub_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              signA_i,
    input  logic              signB_i,
    input  logic [EXP_W-1:0]  expA_i,
    input  logic [EXP_W-1:0]  expB_i,
    input  logic [MANT_W:0]   mantA_i,
    input  logic [MANT_W:0]   mantB_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [TAG_W-1:0]  tag_o,
    output logic              sign_o,
    output logic [EXP_W+1:0]  exp_o,
    output logic [MANT_W+4:0] mant_o
`ifdef VFPU_ADD_SPECIAL_EN
    ,
    output logic [2:0]        special_o
`endif
);

    localparam int RES_W = MANT_W + 5;

    // Stage occupancy and load enables
    logic vld_p0, vld_p1, vld_p2;
    logic ld0, ld1, ld2;

    assign ld2        = ~vld_p2 | out_ready_i;
    assign ld1        = ~vld_p1 | ld2;
    assign ld0        = ~vld_p0 | ld1;
    assign in_ready_o = ld0;

    // ---------------- Stage 1: compare / swap ----------------
    vfpu_add_s1_t s1Next, s1_p0;
    logic         aLarger;
    logic         signBEff;
`ifdef VFPU_ADD_SPECIAL_EN
    logic         aNan, bNan, aInf, bInf;
`endif

    // Pick the larger-magnitude operand and the exponent distance
    always_comb begin
        signBEff = signB_i ^ op_sub_i;
        if (expA_i != expB_i) aLarger = (expA_i > expB_i);
        else                  aLarger = (mantA_i >= mantB_i);

        s1Next         = '0;
        s1Next.tag     = tag_i;
        s1Next.effSub  = signA_i ^ signBEff;
        s1Next.expDiff = (expA_i >= expB_i) ? (expA_i - expB_i) : (expB_i - expA_i);
        if (aLarger) begin
            s1Next.bigSign   = signA_i;
            s1Next.bigExp    = expA_i;
            s1Next.bigMant   = mantA_i;
            s1Next.smallMant = mantB_i;
        end else begin
            s1Next.bigSign   = signBEff;
            s1Next.bigExp    = expB_i;
            s1Next.bigMant   = mantB_i;
            s1Next.smallMant = mantA_i;
        end
`ifdef VFPU_ADD_SPECIAL_EN
        aNan = (&expA_i) & (|mantA_i[MANT_W-1:0]);
        bNan = (&expB_i) & (|mantB_i[MANT_W-1:0]);
        aInf = (&expA_i) & ~(|mantA_i[MANT_W-1:0]);
        bInf = (&expB_i) & ~(|mantB_i[MANT_W-1:0]);
        s1Next.isNan   = aNan | bNan | (aInf & bInf & s1Next.effSub);
        s1Next.isInf   = ~s1Next.isNan & (aInf | bInf);
        s1Next.infSign = aInf ? signA_i : signBEff;
`endif
    end

    // Stage-1 register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0 <= 1'b0;
            s1_p0  <= '0;
        end else begin
            if (ld0) vld_p0 <= in_valid_i;
            if (ld0 && in_valid_i) s1_p0 <= s1Next;
        end
    end

    // ---------------- Stage 2: align ----------------
    vfpu_add_s2_t            s2Next, s2_p1;
    logic [MANT_ALIGN_W-1:0] smallShifted;

    vfpu_align_shift #(
        .WIDTH  (MANT_ALIGN_W),
        .SHIFT_W(EXP_W)
    ) uAlign (
        .dataIn ({s1_p0.smallMant, 3'b000}),
        .shAmt  (s1_p0.expDiff),
        .dataOut(smallShifted)
    );

    // Extend the big mantissa with zero G/R/S and pass the aligned small one
    always_comb begin
        s2Next              = '0;
        s2Next.tag          = s1_p0.tag;
        s2Next.bigSign      = s1_p0.bigSign;
        s2Next.effSub       = s1_p0.effSub;
        s2Next.bigExp       = s1_p0.bigExp;
        s2Next.bigAligned   = {s1_p0.bigMant, 3'b000};
        s2Next.smallAligned = smallShifted;
`ifdef VFPU_ADD_SPECIAL_EN
        s2Next.isNan        = s1_p0.isNan;
        s2Next.isInf        = s1_p0.isInf;
        s2Next.infSign      = s1_p0.infSign;
`endif
    end

    // Stage-2 register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            s2_p1  <= '0;
        end else begin
            if (ld1) vld_p1 <= vld_p0;
            if (ld1 && vld_p0) s2_p1 <= s2Next;
        end
    end

    // ---------------- Stage 3: add / subtract ----------------
    logic [RES_W-1:0]         sumFull;
    logic                     resZero;
    logic                     signNext;
    logic [RES_W-1:0]         mantNext;
    logic [EXP_PRENORM_W-1:0] expNext;
`ifdef VFPU_ADD_SPECIAL_EN
    logic [2:0]               specialNext;
`endif

    // Magnitude add, or subtract via two's complement of the smaller operand
    always_comb begin
        if (s2_p1.effSub) begin
            sumFull = {1'b0, s2_p1.bigAligned} + {1'b0, ~s2_p1.smallAligned} + RES_W'(1);
            sumFull[RES_W-1] = 1'b0;
        end else begin
            sumFull = {1'b0, s2_p1.bigAligned} + {1'b0, s2_p1.smallAligned};
        end
        resZero  = (sumFull == '0);
        // Exact cancellation yields +0 under round-to-nearest
        signNext = (s2_p1.effSub && resZero) ? 1'b0 : s2_p1.bigSign;
        mantNext = sumFull;
        expNext  = {2'b00, s2_p1.bigExp};
`ifdef VFPU_ADD_SPECIAL_EN
        specialNext = {s2_p1.isNan, s2_p1.isInf,
                       ~s2_p1.isNan & ~s2_p1.isInf & resZero};
        if (s2_p1.isNan || s2_p1.isInf) mantNext = '0;
        if (s2_p1.isInf) signNext = s2_p1.infSign;
`endif
    end

    logic [TAG_W-1:0]         tagRes_p2;
    logic                     signRes_p2;
    logic [EXP_PRENORM_W-1:0] expRes_p2;
    logic [RES_W-1:0]         mantRes_p2;
`ifdef VFPU_ADD_SPECIAL_EN
    logic [2:0]               special_p2;
`endif

    // Output register, held while downstream stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2     <= 1'b0;
            tagRes_p2  <= '0;
            signRes_p2 <= 1'b0;
            expRes_p2  <= '0;
            mantRes_p2 <= '0;
`ifdef VFPU_ADD_SPECIAL_EN
            special_p2 <= '0;
`endif
        end else begin
            if (ld2) vld_p2 <= vld_p1;
            if (ld2 && vld_p1) begin
                tagRes_p2  <= s2_p1.tag;
                signRes_p2 <= signNext;
                expRes_p2  <= expNext;
                mantRes_p2 <= mantNext;
`ifdef VFPU_ADD_SPECIAL_EN
                special_p2 <= specialNext;
`endif
            end
        end
    end

    assign out_valid_o = vld_p2;
    assign tag_o       = tagRes_p2;
    assign sign_o      = signRes_p2;
    assign exp_o       = expRes_p2;
    assign mant_o      = mantRes_p2;
`ifdef VFPU_ADD_SPECIAL_EN
    assign special_o   = special_p2;
`endif

endmodule

// File: tb/tb_vfpu_add_pipe.sv
// Scoreboard bench for vfpu_add_pipe: the driver pushes expected results,
// a monitor pops and compares whenever a result is handed downstream.
module tb_vfpu_add_pipe;

    logic        clk;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        op_sub_i;
    logic [3:0]  tag_i;
    logic        signA_i, signB_i;
    logic [7:0]  expA_i, expB_i;
    logic [23:0] mantA_i, mantB_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  tag_o;
    logic        sign_o;
    logic [9:0]  exp_o;
    logic [27:0] mant_o;
`ifdef VFPU_ADD_SPECIAL_EN
    logic [2:0]  special_o;
`endif

    vfpu_add_pipe dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .op_sub_i   (op_sub_i),
        .tag_i      (tag_i),
        .signA_i    (signA_i),
        .signB_i    (signB_i),
        .expA_i     (expA_i),
        .expB_i     (expB_i),
        .mantA_i    (mantA_i),
        .mantB_i    (mantB_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .tag_o      (tag_o),
        .sign_o     (sign_o),
        .exp_o      (exp_o),
        .mant_o     (mant_o)
`ifdef VFPU_ADD_SPECIAL_EN
        ,
        .special_o  (special_o)
`endif
    );

    typedef struct {
        bit [3:0]  tag;
        bit        sub;
        bit        sA;
        bit        sB;
        bit [7:0]  eA;
        bit [7:0]  eB;
        bit [23:0] mA;
        bit [23:0] mB;
    } opT;

    typedef struct {
        bit [3:0]  tag;
        bit        sign;
        bit [9:0]  exp;
        bit [27:0] mant;
    } expT;

    expT expQ[$];
    time popT[$];
    int  tests = 0;
    int  fails = 0;
    bit  rndReady = 0;
    bit  readyVal = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: pick larger magnitude, align with exact sticky, add/sub integers.
    function automatic expT model(input opT o);
        expT    r;
        longint kA, kB, bigM, smlM, sm8, bm8, al, res;
        int     bigE, smlE, d;
        bit     sBe, aBig, bigS, eff;
        kA   = (longint'(o.eA) <<< 25) + longint'(o.mA);
        kB   = (longint'(o.eB) <<< 25) + longint'(o.mB);
        aBig = (kA >= kB);
        sBe  = o.sB ^ o.sub;
        if (aBig) begin
            bigE = int'(o.eA); smlE = int'(o.eB);
            bigM = longint'(o.mA); smlM = longint'(o.mB); bigS = o.sA;
        end else begin
            bigE = int'(o.eB); smlE = int'(o.eA);
            bigM = longint'(o.mB); smlM = longint'(o.mA); bigS = sBe;
        end
        d   = (bigE >= smlE) ? bigE - smlE : smlE - bigE;
        sm8 = smlM * 8;
        bm8 = bigM * 8;
        if (d >= 40) begin
            al = (sm8 != 0) ? 1 : 0;
        end else begin
            al = sm8 >> d;
            if ((sm8 & ((longint'(1) << d) - 1)) != 0) al = al | 1;
        end
        eff    = o.sA ^ sBe;
        res    = eff ? (bm8 - al) : (bm8 + al);
        r.tag  = o.tag;
        r.sign = (eff && res == 0) ? 1'b0 : bigS;
        r.exp  = 10'(bigE);
        r.mant = 28'(res);
        return r;
    endfunction

    function automatic opT mkOp(input bit [3:0] tag, input bit sub, input bit sA, input bit sB,
                                input bit [7:0] eA, input bit [7:0] eB,
                                input bit [23:0] mA, input bit [23:0] mB);
        opT o;
        o.tag = tag; o.sub = sub; o.sA = sA; o.sB = sB;
        o.eA = eA; o.eB = eB; o.mA = mA; o.mB = mB;
        return o;
    endfunction

    function automatic expT mkExp(input bit [3:0] tag, input bit sign, input bit [9:0] e,
                                  input bit [27:0] m);
        expT r;
        r.tag = tag; r.sign = sign; r.exp = e; r.mant = m;
        return r;
    endfunction

    function automatic opT randOp();
        opT o;
        int off, eb;
        o.tag = 4'($urandom);
        o.sub = 1'($urandom);
        o.sA  = 1'($urandom);
        o.sB  = 1'($urandom);
        o.eA  = 8'($urandom_range(1, 254));
        off   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 70)) - 35;
        eb    = int'(o.eA) + off;
        if (eb < 0) eb = 0;
        if (eb > 255) eb = 255;
        o.eB  = 8'(eb);
        o.mA  = {1'b1, 23'($urandom)};
        o.mB  = ($urandom_range(0, 3) == 0) ? o.mA : {1'b1, 23'($urandom)};
        return o;
    endfunction

    task automatic driveOp(input opT o);
        in_valid_i = 1'b1;
        op_sub_i   = o.sub;
        tag_i      = o.tag;
        signA_i    = o.sA;
        signB_i    = o.sB;
        expA_i     = o.eA;
        expB_i     = o.eB;
        mantA_i    = o.mA;
        mantB_i    = o.mB;
    endtask

    // Present an operation and hold it until accepted; push the given expectation.
    task automatic sendOpExp(input opT o, input expT e);
        int cnt = 0;
        @(negedge clk);
        driveOp(o);
        #1;
        while (!in_ready_o && cnt < 200) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (in_ready_o) expQ.push_back(e);
        else begin
            check("accept_timeout", 64'(in_ready_o), 64'd1);
            in_valid_i = 1'b0;
        end
    endtask

    task automatic sendOp(input opT o);
        sendOpExp(o, model(o));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int cnt = 0;
        while (expQ.size() != 0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        repeat (4) @(negedge clk);
        check("drain_empty", 64'(expQ.size()), 64'd0);
    endtask

    // Downstream ready: random or held at readyVal
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            out_ready_i = rndReady ? ($urandom_range(0, 3) != 0) : readyVal;
        end
    end

    // Monitor: a result transfers on the next edge whenever valid&ready
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_i && out_valid_o && out_ready_i) begin
                if (expQ.size() == 0) begin
                    check("unexpected_output", 64'(out_valid_o), 64'd0);
                end else begin
                    e = expQ.pop_front();
                    check("tag",  64'(tag_o),  64'(e.tag));
                    check("sign", 64'(sign_o), 64'(e.sign));
                    check("exp",  64'(exp_o),  64'(e.exp));
                    check("mant", 64'(mant_o), 64'(e.mant));
                    popT.push_back($time);
                end
            end
        end
    end

    initial begin
        opT          bp[5];
        int          idx;
        int          popBase;
        int          seen;
        logic [43:0] snap;

        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        op_sub_i   = 1'b0;
        tag_i      = '0;
        signA_i    = 1'b0;
        signB_i    = 1'b0;
        expA_i     = '0;
        expB_i     = '0;
        mantA_i    = '0;
        mantB_i    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready",  64'(in_ready_o),  64'd1);
        check("rst_sign",      64'(sign_o),      64'd0);
        check("rst_exp",       64'(exp_o),       64'd0);
        check("rst_mant",      64'(mant_o),      64'd0);
        check("rst_tag",       64'(tag_o),       64'd0);
        rst_i = 1'b0;

        // Directed vectors with hand-derived results
        sendOpExp(mkOp(4'h1, 0, 0, 0, 8'd127, 8'd127, 24'h800000, 24'h800000),
                  mkExp(4'h1, 0, 10'd127, 28'h8000000));
        sendOpExp(mkOp(4'h2, 1, 0, 0, 8'd127, 8'd127, 24'hC00000, 24'hC00000),
                  mkExp(4'h2, 0, 10'd127, 28'h0));
        sendOpExp(mkOp(4'h3, 1, 1, 1, 8'd127, 8'd127, 24'hC00000, 24'hC00000),
                  mkExp(4'h3, 0, 10'd127, 28'h0));
        sendOpExp(mkOp(4'h4, 0, 0, 0, 8'd127, 8'd97, 24'h800000, 24'h800000),
                  mkExp(4'h4, 0, 10'd127, 28'h4000001));
        sendOpExp(mkOp(4'h5, 1, 0, 0, 8'd127, 8'd128, 24'h800000, 24'h800000),
                  mkExp(4'h5, 1, 10'd128, 28'h2000000));
        // Alignment boundaries and equal-exponent ordering
        sendOp(mkOp(4'h6, 1, 0, 0, 8'd127, 8'd101, 24'h800000, 24'hFFFFFF));
        sendOp(mkOp(4'h7, 0, 0, 0, 8'd127, 8'd100, 24'h800000, 24'h800001));
        sendOp(mkOp(4'h8, 1, 0, 1, 8'd127, 8'd99,  24'h800000, 24'h800001));
        sendOp(mkOp(4'h9, 0, 1, 0, 8'd50,  8'd50,  24'h800000, 24'h900000));
        sendOp(mkOp(4'hA, 1, 0, 0, 8'd50,  8'd50,  24'h800000, 24'h900000));
        sendOp(mkOp(4'hB, 0, 0, 0, 8'd200, 8'd199, 24'hFFFFFF, 24'hFFFFFF));
        idle();
        drain();

        // Backpressure: three accepted, then in_ready drops and outputs hold
        for (int i = 0; i < 5; i++) bp[i] = randOp();
        for (int i = 0; i < 5; i++) bp[i].tag = 4'(i + 1);
        readyVal = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (idx < 5) driveOp(bp[idx]);
            else in_valid_i = 1'b0;
            #1;
            if (in_ready_o && in_valid_i) begin
                expQ.push_back(model(bp[idx]));
                idx++;
            end
        end
        check("bp_accepted",  64'(idx),         64'd3);
        check("bp_in_ready",  64'(in_ready_o),  64'd0);
        check("bp_out_valid", 64'(out_valid_o), 64'd1);
        snap = {tag_o, sign_o, exp_o, mant_o};
        repeat (3) @(negedge clk);
        #1;
        check("bp_stable", 64'({tag_o, sign_o, exp_o, mant_o}), 64'(snap));
        check("bp_valid_held", 64'(out_valid_o), 64'd1);
        readyVal = 1'b1;
        popBase = popT.size();
        sendOp(bp[3]);
        sendOp(bp[4]);
        idle();
        drain();
        if (popT.size() >= popBase + 5)
            check("bp_throughput", 64'(popT[popBase+4] - popT[popBase]), 64'd40);
        else
            check("bp_pop_count", 64'(popT.size() - popBase), 64'd5);

        // Reset with two operations in flight
        sendOp(randOp());
        sendOp(randOp());
        @(posedge clk);
        #3;
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid_o), 64'd0);
        check("midrst_in_ready",  64'(in_ready_o),  64'd1);
        check("midrst_mant",      64'(mant_o),      64'd0);
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (out_valid_o) seen++;
        end
        check("midrst_no_stale", 64'(seen), 64'd0);

        // Random traffic with random downstream stalls
        rndReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else sendOp(randOp());
        end
        idle();
        rndReady = 1'b0;
        readyVal = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
